// File: rtl/lcd_bus_responder_if.sv
// HD44780-style 8-bit LCD bus as seen between the LCD writer (master) and the responder (slave).
interface lcd_bus_responder_if;
    logic       en;
    logic       rs;
    logic       rw;
    logic [7:0] data;
    logic [7:0] dout;
    logic       dout_oe;
    logic       busy;

    modport master (output en, rs, rw, data, input dout, dout_oe, busy);
    modport slave  (input en, rs, rw, data, output dout, dout_oe, busy);
endinterface

// File: rtl/lcd_bus_responder.sv
// LCD bus responder: decodes HD44780-style commands/data into a 2x16 character buffer,
// answers status/data reads and exposes the buffer through a registered observe port.
//   state   | meaning
//   S_CLEAR | sweeping 0x20 into all 32 cells, one per cycle
//   S_IDLE  | ready, accepts writes
//   S_EXEC  | one-cycle command decode / busy load
//   S_BUSY  | busy counter running down
module lcd_bus_responder #(
    parameter int BUSY_SHORT = 2000,
    parameter int BUSY_LONG  = 82000
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    lcd_bus_responder_if.slave  bus,
    input  logic [4:0]          rd_addr,
    output logic [7:0]          rd_char,
    output logic                disp_on,
    output logic [4:0]          ac,
    output logic                overrun
);
    localparam int CNT_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LOAD_SHORT = CW'(BUSY_SHORT);
    localparam logic [CW-1:0] LOAD_LONG  = CW'(BUSY_LONG);
    localparam logic [CW-1:0] LOAD_SWEEP = CW'(BUSY_LONG - 32);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_EXEC, S_BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    ac_clr;
    logic          inc;
    logic          busy_q;
    logic [7:0]    dout_q;

    logic          s1_en, s1_rs, s1_rw, s2_en, s2_rs, s2_rw;
    logic [7:0]    s1_data, s2_data;
    logic          en_prev;
    logic          cap_rs, cap_rw;
    logic [7:0]    cap_data;
    logic          cmd_rs;
    logic [7:0]    cmd_data;

    logic          fall, wr_commit, rd_commit;

    logic [7:0]    mem [32];
    logic          mem_we;
    logic [4:0]    mem_addr;
    logic [7:0]    mem_wdata;

    function automatic logic [4:0] step(input logic [4:0] a, input logic up);
        return up ? a + 5'd1 : a - 5'd1;
    endfunction

    assign fall      = en_prev & ~s2_en;
    assign wr_commit = fall & ~cap_rw;
    assign rd_commit = fall & cap_rw;

    assign bus.dout    = dout_q;
    assign bus.dout_oe = s2_en & s2_rw;
    assign bus.busy    = busy_q;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            s1_en    <= 1'b0;
            s1_rs    <= 1'b0;
            s1_rw    <= 1'b0;
            s1_data  <= 8'h00;
            s2_en    <= 1'b0;
            s2_rs    <= 1'b0;
            s2_rw    <= 1'b0;
            s2_data  <= 8'h00;
            en_prev  <= 1'b0;
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
        end else begin
            s1_en   <= bus.en;
            s1_rs   <= bus.rs;
            s1_rw   <= bus.rw;
            s1_data <= bus.data;
            s2_en   <= s1_en;
            s2_rs   <= s1_rs;
            s2_rw   <= s1_rw;
            s2_data <= s1_data;
            en_prev <= s2_en;
            if (s2_en) begin
                cap_rs   <= s2_rs;
                cap_rw   <= s2_rw;
                cap_data <= s2_data;
            end
        end
    end

    // Data writes land in the commit cycle so the observe port sees them one cycle later.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ac;
        mem_wdata = cap_data;
        if (state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = ac_clr;
            mem_wdata = 8'h20;
        end else if (state == S_IDLE && wr_commit && cap_rs) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            rd_char <= 8'h20;
            dout_q  <= 8'h80;
        end else begin
            rd_char <= mem[rd_addr];
            if (s2_en && s2_rw)
                dout_q <= s2_rs ? mem[ac] : {busy_q, ac[4], 2'b00, ac[3:0]};
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state    <= S_CLEAR;
            cnt      <= '0;
            ac_clr   <= 5'd0;
            ac       <= 5'd0;
            inc      <= 1'b1;
            disp_on  <= 1'b0;
            busy_q   <= 1'b1;
            overrun  <= 1'b0;
            cmd_rs   <= 1'b0;
            cmd_data <= 8'h00;
        end else begin
            if (wr_commit && state != S_IDLE) overrun <= 1'b1;
            if (rd_commit && cap_rs) ac <= step(ac, inc);

            case (state)
                S_CLEAR: begin
                    ac_clr <= ac_clr + 5'd1;
                    if (ac_clr == 5'd31) begin
                        if (BUSY_LONG > 32) begin
                            state <= S_BUSY;
                            cnt   <= LOAD_SWEEP;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    if (wr_commit) begin
                        state    <= S_EXEC;
                        busy_q   <= 1'b1;
                        cmd_rs   <= cap_rs;
                        cmd_data <= cap_data;
                        if (cap_rs) ac <= step(ac, inc);
                    end
                end
                S_EXEC: begin
                    state <= S_BUSY;
                    cnt   <= LOAD_SHORT;
                    // Highest set bit selects the command; cursor/blink and shift bits have no effect here.
                    if (!cmd_rs) begin
                        casez (cmd_data)
                            8'b1???????: ac <= {cmd_data[6], cmd_data[3:0]};
                            8'b01??????, 8'b001?????: ;
                            8'b0001????: if (!cmd_data[3]) ac <= step(ac, cmd_data[2]);
                            8'b00001???: disp_on <= cmd_data[2];
                            8'b000001??: inc <= cmd_data[1];
                            8'b0000001?: begin
                                ac  <= 5'd0;
                                cnt <= LOAD_LONG;
                            end
                            8'b00000001: begin
                                ac     <= 5'd0;
                                inc    <= 1'b1;
                                ac_clr <= 5'd0;
                                state  <= S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_CLEAR;
                    ac_clr <= 5'd0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: bus writes/reads with busy timing, buffer contents via the observe port.
module tb_lcd_bus_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       disp_on;
    logic [4:0] ac;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] val;
    } cell_t;

    cell_t      cell_q[$];
    logic [7:0] rd_q[$];

    lcd_bus_responder_if bus();

    lcd_bus_responder #(.BUSY_SHORT(4), .BUSY_LONG(40)) u_dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .bus      (bus),
        .rd_addr  (rd_addr),
        .rd_char  (rd_char),
        .disp_on  (disp_on),
        .ac       (ac),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic rs_v, input logic [7:0] d);
        bus.rs   = rs_v;
        bus.rw   = 1'b0;
        bus.data = d;
        bus.en   = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Counts post-edge samples with busy high; bounded so a stuck flag still reaches the summary.
    task automatic wait_busy(output int n);
        for (int i = 0; i < 10 && !bus.busy; i++) begin
            @(posedge clk);
            #1;
        end
        n = 0;
        while (bus.busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic write_check(input logic rs_v, input logic [7:0] d, input int exp_n, input string tag);
        int n;
        bus_write(rs_v, d);
        wait_busy(n);
        check(tag, n, exp_n);
    endtask

    task automatic bus_read(input logic rs_v, input logic [7:0] exp, input string tag);
        rd_q.push_back(exp);
        bus.rs = rs_v;
        bus.rw = 1'b1;
        bus.en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_oe"}, bus.dout_oe, 1);
        check(tag, bus.dout, rd_q.pop_front());
        bus.en = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.rw = 1'b0;
    endtask

    task automatic push_cell(input logic [4:0] a, input logic [7:0] v);
        cell_t c;
        c.addr = a;
        c.val  = v;
        cell_q.push_back(c);
    endtask

    task automatic push_all_blank();
        for (int i = 0; i < 32; i++) push_cell(5'(i), 8'h20);
    endtask

    task automatic check_cells();
        cell_t c;
        while (cell_q.size() > 0) begin
            c = cell_q.pop_front();
            rd_addr = c.addr;
            @(posedge clk);
            #1;
            check($sformatf("cell%0d", c.addr), rd_char, c.val);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] mid;

        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.rs   = 1'b0;
        bus.rw   = 1'b0;
        bus.data = 8'h00;
        rd_addr  = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", bus.dout, 8'h80);
        check("rst_dout_oe", bus.dout_oe, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_rd_char", rd_char, 8'h20);
        check("rst_disp_on", disp_on, 0);
        check("rst_ac", ac, 0);
        check("rst_overrun", overrun, 0);

        rst = 1'b0;
        wait_busy(n);
        check("busy_after_reset", n, 40);
        push_all_blank();
        check_cells();
        check("ac_after_reset", ac, 0);

        write_check(1'b0, 8'h80, 5, "busy_set_ddram");
        write_check(1'b0, 8'h0C, 5, "busy_disp_ctrl");
        write_check(1'b1, 8'h31, 5, "busy_data_1");
        write_check(1'b1, 8'h32, 5, "busy_data_2");
        write_check(1'b1, 8'h2B, 5, "busy_data_plus");
        write_check(1'b1, 8'h33, 5, "busy_data_3");
        push_cell(5'd0, 8'h31);
        push_cell(5'd1, 8'h32);
        push_cell(5'd2, 8'h2B);
        push_cell(5'd3, 8'h33);
        check_cells();
        check("ac_after_text", ac, 4);
        check("disp_on_set", disp_on, 1);

        write_check(1'b0, 8'h80, 5, "busy_home_addr");
        bus_read(1'b1, 8'h31, "data_read");
        check("ac_after_data_read", ac, 1);

        write_check(1'b0, 8'hCF, 5, "busy_set_line2_end");
        check("ac_line2_end", ac, 31);
        write_check(1'b1, 8'h41, 5, "busy_data_A");
        bus_write(1'b1, 8'h42);
        bus_read(1'b0, 8'h81, "status_while_busy");
        wait_busy(n);
        bus_read(1'b0, 8'h01, "status_idle");
        push_cell(5'd31, 8'h41);
        push_cell(5'd0, 8'h42);
        check_cells();
        check("ac_wrapped", ac, 1);

        write_check(1'b0, 8'h04, 5, "busy_entry_dec");
        write_check(1'b0, 8'h80, 5, "busy_addr0");
        write_check(1'b1, 8'h35, 5, "busy_data_5");
        push_cell(5'd0, 8'h35);
        check_cells();
        check("ac_dec_wrap", ac, 31);

        // Second write commits on the last busy cycle and must be dropped.
        bus_write(1'b1, 8'h55);
        bus_write(1'b1, 8'h66);
        wait_busy(n);
        check("overrun_set", overrun, 1);
        check("ac_after_drop", ac, 30);
        push_cell(5'd31, 8'h55);
        push_cell(5'd30, 8'h20);
        check_cells();
        write_check(1'b0, 8'h06, 5, "busy_entry_inc");
        check("overrun_sticky", overrun, 1);

        write_check(1'b0, 8'h01, 41, "busy_clear");
        push_all_blank();
        check_cells();
        check("ac_after_clear", ac, 0);

        write_check(1'b0, 8'hC4, 5, "busy_set_20");
        write_check(1'b1, 8'h5A, 5, "busy_data_Z");
        push_cell(5'd20, 8'h5A);
        check_cells();
        check("ac_after_Z", ac, 21);
        check("overrun_still_set", overrun, 1);

        rd_addr = 5'd20;
        bus_write(1'b0, 8'h01);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mid = 8'h00;
        n = 0;
        while (bus.busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 12) mid = rd_char;
        end
        check("sweep_restart_cell20", mid, 8'h5A);
        check("busy_after_mid_reset", n, 40);
        push_all_blank();
        check_cells();
        check("ac_after_mid_reset", ac, 0);
        check("overrun_cleared", overrun, 0);
        check("disp_on_cleared", disp_on, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
